array_stream_reader: RTL and testbench
======================================

# array_stream_reader

Downstream consumer of the `Array` register file. On a start pulse it snapshots the packed `array` output and streams the elements out one per cycle over a valid/ready handshake, tagging each with its index and a last flag. It also accumulates the bitwise OR of every element it delivers, giving the same value as an OR reduction over the streamed elements. Typical use: draining an accumulated table to a serial sink or bus without stalling further writes to `Array`.

## Interface
Parameters:
- `ELEMENTS`, default 16: number of array entries; must be at least 2.
- `WIDTH`, default 32: bits per entry.

Ports:
- `clock`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `array`, input, [ELEMENTS-1:0][WIDTH-1:0]: packed array, driven directly from `Array.array`.
- `start`, input, 1: begins a scan; sampled only in IDLE.
- `out_ready`, input, 1: sink can accept the element.
- `out_valid`, output, 1: `out_data`, `out_index` and `out_last` are valid.
- `out_data`, output, WIDTH: current element.
- `out_index`, output, $clog2(ELEMENTS): index of the current element.
- `out_last`, output, 1: the current element is the final one of this scan.
- `busy`, output, 1: high in every state except IDLE.
- `done`, output, 1: one-cycle pulse after the scan completes.
- `or_result`, output, WIDTH: OR of all elements accepted in the current or most recent scan.

## Operation
- States are IDLE, SEND and DONE.
- IDLE:
  - If `start` is high, copy `array` into an internal snapshot, clear `or_result` to 0 and set the pointer to the first element to send (index 0).
  - Then go to SEND, or to DONE if there is nothing to send (only possible with the skip feature).
- SEND:
  - `out_valid` = 1 and outputs reflect the snapshot at the pointer.
  - A handshake occurs when `out_valid` and `out_ready` are both high in the same cycle.
  - On each handshake, `or_result |= out_data`.
  - If `out_last` is set, go to DONE; otherwise advance the pointer to the next element to send.
- DONE: `done` = 1 for exactly one cycle, then go to IDLE.
- `or_result` holds its value in IDLE until the next `start`.
- The snapshot isolates the scan from later writes to `Array`; mid-scan writes are not visible.
- `start` in SEND or DONE is ignored; it is not queued.
- Arithmetic and width rules:
  - The pointer is $clog2(ELEMENTS) bits wide.
  - `out_last` is asserted when the pointer equals ELEMENTS-1, or, in skip mode, when no later element is selected.
  - No wrap-around occurs: the scan ends at the last element.

## Timing
- Reset values:
  - State is IDLE.
  - `out_valid`, `out_last`, `busy` and `done` are 0.
  - `out_data`, `out_index`, `or_result` and the snapshot are 0.
- A reset asserted mid-scan aborts the scan and forces reset values on the next edge. No `done` pulse is produced.
- Start latency:
  - `start` high in cycle N (IDLE) gives `out_valid` high in cycle N+1 with the first element.
  - `busy` rises in N+1.
- Throughput: one element per cycle while `out_ready` stays high.
- Backpressure: while `out_valid` && !`out_ready`, all of `out_data`, `out_index` and `out_last` stay stable.
- `out_valid` never drops before its handshake.
- Completion:
  - A handshake on the last element in cycle M gives `done` = 1 in M+1.
  - `busy` = 1 in M+1 and `busy` = 0 in M+2.
  - A new `start` is accepted from M+2.
- Full scan, dense mode, `out_ready` held high: the 16 elements appear in N+1 through N+16 and `done` pulses in N+17.
- `out_ready` high while `out_valid` is low has no effect.

## Configuration
- Macro: `ARRAY_STREAM_READER_SKIP_ZERO_EN`.
- Defined:
  - Elements equal to zero in the snapshot are not emitted. The pointer moves to the next nonzero index using combinational lookahead over the snapshot's nonzero mask, with no bubble cycles.
  - `out_last` marks the last nonzero element.
  - If every element is zero, the block goes IDLE -> DONE directly: `done` pulses in N+1, `out_valid` is never raised and `or_result` is 0.
- Undefined: every element is emitted in index order, 0 to ELEMENTS-1, and no mask logic is compiled.

## Test plan
- Dense scan, ELEMENTS=16, element i = i+1, `out_ready` = 1, pulse `start` -> 16 beats with `out_index` 0..15 and data 1..16. `out_last` is set only on index 15, `done` pulses in N+17, `or_result` = 0x1F.
- Backpressure: toggle `out_ready` every cycle -> each beat holds stable until accepted. There is no duplication or loss, and `done` arrives after 16 handshakes.
- Snapshot isolation: after `start`, write 0xFFFFFFFF into `Array` index 3 -> the stream still shows the original value at index 3.
- `start` asserted during SEND and during DONE -> ignored; exactly one scan and one `done` pulse.
- Reset at the 5th beat -> all outputs return to 0 the next cycle with no `done` pulse; a following `start` restarts at index 0.
- SKIP_ZERO_EN, only indices 2 and 9 nonzero (0xA, 0x50) -> two back-to-back beats, with `out_last` on index 9 and `or_result` = 0x5A. A second case with all elements zero -> `done` pulses in N+1 and `out_valid` is never asserted.

Source files
------------

// File: rtl/array_stream_reader.sv
// Snapshots a packed register-file array on start and streams it out over valid/ready.
// Optional macro ARRAY_STREAM_READER_SKIP_ZERO_EN suppresses zero elements with no bubbles.
module array_stream_reader #(
    parameter int ELEMENTS = 16,
    parameter int WIDTH    = 32
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [ELEMENTS-1:0][WIDTH-1:0]      array,
    input  logic                                start,
    input  logic                                out_ready,
    output logic                                out_valid,
    output logic [WIDTH-1:0]                    out_data,
    output logic [$clog2(ELEMENTS)-1:0]         out_index,
    output logic                                out_last,
    output logic                                busy,
    output logic                                done,
    output logic [WIDTH-1:0]                    or_result
);

    localparam int IW = $clog2(ELEMENTS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                          state_q, state_d;
    logic [ELEMENTS-1:0][WIDTH-1:0]  snap_q;
    logic [IW-1:0]                   ptr_q, ptr_d;
    logic [WIDTH-1:0]                or_q;
    logic                            hs;
    logic                            last;
    logic                            first_found;
    logic [IW-1:0]                   first_idx;
    logic [IW-1:0]                   next_idx;

`ifdef ARRAY_STREAM_READER_SKIP_ZERO_EN
    function automatic logic [ELEMENTS-1:0] nz_mask(input logic [ELEMENTS-1:0][WIDTH-1:0] a);
        logic [ELEMENTS-1:0] m;
        for (int i = 0; i < ELEMENTS; i++) begin
            m[i] = |a[i];
        end
        return m;
    endfunction

    // Lowest set bit at or above lo; MSB of the result flags whether one exists.
    function automatic logic [IW:0] first_at_or_after(input logic [ELEMENTS-1:0] m, input int lo);
        logic [IW:0] r;
        r = '0;
        for (int i = ELEMENTS - 1; i >= 0; i--) begin
            if (i >= lo && m[i]) begin
                r = {1'b1, IW'(i)};
            end
        end
        return r;
    endfunction

    logic [IW:0] first_sel;
    logic [IW:0] next_sel;

    assign first_sel   = first_at_or_after(nz_mask(array), 0);
    assign next_sel    = first_at_or_after(nz_mask(snap_q), int'(ptr_q) + 1);
    assign first_found = first_sel[IW];
    assign first_idx   = first_sel[IW-1:0];
    assign next_idx    = next_sel[IW-1:0];
    assign last        = !next_sel[IW];
`else
    assign first_found = 1'b1;
    assign first_idx   = '0;
    assign next_idx    = ptr_q + IW'(1);
    assign last        = (ptr_q == IW'(ELEMENTS - 1));
`endif

    assign out_valid = (state_q == SEND);
    assign out_data  = snap_q[ptr_q];
    assign out_index = ptr_q;
    assign out_last  = out_valid && last;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign or_result = or_q;
    assign hs        = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = first_found ? SEND : DONE;
                    ptr_d   = first_idx;
                end
            end
            SEND: begin
                if (hs) begin
                    if (last) begin
                        state_d = DONE;
                    end else begin
                        ptr_d = next_idx;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            snap_q  <= '0;
            ptr_q   <= '0;
            or_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            if (state_q == IDLE && start) begin
                snap_q <= array;
                or_q   <= '0;
            end else if (hs) begin
                or_q <= or_q | out_data;
            end
        end
    end

endmodule

// File: tb/tb_array_stream_reader.sv
// Directed self-checking bench for array_stream_reader (default 16 x 32 configuration).
module tb_array_stream_reader;

    localparam int ELEMENTS = 16;
    localparam int WIDTH    = 32;

    logic                           clock;
    logic                           reset;
    logic [ELEMENTS-1:0][WIDTH-1:0] arr;
    logic                           start;
    logic                           out_ready;
    logic                           out_valid;
    logic [WIDTH-1:0]               out_data;
    logic [3:0]                     out_index;
    logic                           out_last;
    logic                           busy;
    logic                           done;
    logic [WIDTH-1:0]               or_result;

    int n_checks = 0;
    int n_err    = 0;
    int hs;

    array_stream_reader #(.ELEMENTS(ELEMENTS), .WIDTH(WIDTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .array     (arr),
        .start     (start),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_index (out_index),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .or_result (or_result)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_last"},  {31'd0, out_last},  32'd0);
        chk({tag, "_busy"},  {31'd0, busy},      32'd0);
        chk({tag, "_done"},  {31'd0, done},      32'd0);
        chk({tag, "_data"},  out_data,           32'd0);
        chk({tag, "_index"}, {28'd0, out_index}, 32'd0);
        chk({tag, "_or"},    or_result,          32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < ELEMENTS; i++) arr[i] = 32'(i + 1);
        tick();
        tick();
        chk_idle_zero("reset");
        reset = 1'b0;
        tick();

        // Dense scan, start held high across SEND and DONE must be ignored
        out_ready = 1'b1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 16; k++) begin
            chk("t1_valid", {31'd0, out_valid}, 32'd1);
            chk("t1_index", {28'd0, out_index}, 32'(k));
            chk("t1_data",  out_data,           32'(k + 1));
            chk("t1_last",  {31'd0, out_last},  (k == 15) ? 32'd1 : 32'd0);
            chk("t1_busy",  {31'd0, busy},      32'd1);
            chk("t1_done",  {31'd0, done},      32'd0);
            if (k == 3) start = 1'b1;
            tick();
        end
        chk("t1_done_pulse", {31'd0, done},      32'd1);
        chk("t1_done_busy",  {31'd0, busy},      32'd1);
        chk("t1_done_valid", {31'd0, out_valid}, 32'd0);
        chk("t1_or",         or_result,          32'h1F);
        tick();
        start = 1'b0;
        chk("t1_after_done", {31'd0, done}, 32'd0);
        chk("t1_after_busy", {31'd0, busy}, 32'd0);
        tick();
        chk("t1_no_rescan", {31'd0, busy},      32'd0);
        chk("t1_or_hold",   or_result,          32'h1F);

        // Backpressure: out_ready toggles every cycle
        out_ready = 1'b0;
        start     = 1'b1;
        tick();
        start = 1'b0;
        hs    = 0;
        for (int c = 0; c < 64 && hs < 16; c++) begin
            chk("t2_valid", {31'd0, out_valid}, 32'd1);
            chk("t2_index", {28'd0, out_index}, 32'(hs));
            chk("t2_data",  out_data,           32'(hs + 1));
            chk("t2_last",  {31'd0, out_last},  (hs == 15) ? 32'd1 : 32'd0);
            out_ready = ~out_ready;
            if (out_ready) hs++;
            tick();
        end
        chk("t2_count", 32'(hs), 32'd16);
        chk("t2_done",  {31'd0, done}, 32'd1);
        chk("t2_or",    or_result,     32'h1F);
        out_ready = 1'b1;
        tick();
        chk("t2_idle", {31'd0, busy}, 32'd0);

        // Snapshot isolation from mid-scan writes
        start = 1'b1;
        tick();
        start  = 1'b0;
        arr[3] = 32'hFFFF_FFFF;
        for (int k = 0; k < 16; k++) begin
            chk("t3_index", {28'd0, out_index}, 32'(k));
            chk("t3_data",  out_data,           32'(k + 1));
            tick();
        end
        chk("t3_done", {31'd0, done}, 32'd1);
        chk("t3_or",   or_result,     32'h1F);
        tick();
        arr[3] = 32'd4;

        // Reset during the 5th beat aborts the scan
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        chk("t4_beat5", {28'd0, out_index}, 32'd4);
        reset = 1'b1;
        tick();
        chk_idle_zero("t4_reset");
        reset = 1'b0;
        tick();
        chk("t4_no_done", {31'd0, done}, 32'd0);
        chk("t4_no_busy", {31'd0, busy}, 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t4_restart_valid", {31'd0, out_valid}, 32'd1);
        chk("t4_restart_index", {28'd0, out_index}, 32'd0);
        chk("t4_restart_data",  out_data,           32'd1);
        for (int k = 1; k < 16; k++) tick();
        chk("t4_last_index", {28'd0, out_index}, 32'd15);
        chk("t4_last_flag",  {31'd0, out_last},  32'd1);
        tick();
        chk("t4_done", {31'd0, done}, 32'd1);
        tick();

`ifdef ARRAY_STREAM_READER_SKIP_ZERO_EN
        // Sparse table: only indices 2 and 9 are nonzero
        for (int i = 0; i < ELEMENTS; i++) arr[i] = '0;
        arr[2] = 32'h0A;
        arr[9] = 32'h50;
        start  = 1'b1;
        tick();
        start = 1'b0;
        chk("s1_valid0", {31'd0, out_valid}, 32'd1);
        chk("s1_index0", {28'd0, out_index}, 32'd2);
        chk("s1_data0",  out_data,           32'h0A);
        chk("s1_last0",  {31'd0, out_last},  32'd0);
        tick();
        chk("s1_valid1", {31'd0, out_valid}, 32'd1);
        chk("s1_index1", {28'd0, out_index}, 32'd9);
        chk("s1_data1",  out_data,           32'h50);
        chk("s1_last1",  {31'd0, out_last},  32'd1);
        tick();
        chk("s1_done", {31'd0, done},      32'd1);
        chk("s1_or",   or_result,          32'h5A);
        chk("s1_nov",  {31'd0, out_valid}, 32'd0);
        tick();

        // All-zero table goes straight to DONE
        arr[2] = '0;
        arr[9] = '0;
        start  = 1'b1;
        tick();
        start = 1'b0;
        chk("s2_done",  {31'd0, done},      32'd1);
        chk("s2_valid", {31'd0, out_valid}, 32'd0);
        chk("s2_or",    or_result,          32'd0);
        tick();
        chk("s2_idle",   {31'd0, busy},      32'd0);
        chk("s2_valid2", {31'd0, out_valid}, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
